// File: rtl/lc3b_sram_bridge.sv
// LC-3b word-access bridge to an 8-bit asynchronous SRAM. Each 16-bit access becomes one or two byte
// slots; each slot is WAIT_STATES active cycles followed by one all-high recovery cycle. All strobes are registered.
module lc3b_sram_bridge #(
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  mem_byte_enable,
   input  logic [15:0] mem_address,
   input  logic [15:0] mem_wdata,
   output logic        mem_resp,
   output logic [15:0] mem_rdata,
   output logic [15:0] sram_addr,
   output logic [7:0]  sram_wdata,
   input  logic [7:0]  sram_rdata,
   output logic        sram_ce_n,
   output logic        sram_oe_n,
   output logic        sram_we_n
);

   typedef enum logic [2:0] {IDLE, LO_ACT, LO_GAP, HI_ACT, HI_GAP, RESP} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(WAIT_STATES - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        wr_q, hi_q;
   logic [14:0] addr_q;
   logic [7:0]  wdata_hi_q;

   logic        req, wr_e, hi_e, lo_e, act;
   logic [14:0] addr_e;
   logic [7:0]  wdata_hi_e;

   logic        resp_q, resp_d;
   logic [15:0] rdata_q, rdata_d;
   logic [15:0] sram_addr_q, sram_addr_d;
   logic [7:0]  sram_wdata_q, sram_wdata_d;
   logic        ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
   logic        unused_addr0;

   assign req          = mem_read | mem_write;
   assign unused_addr0 = mem_address[0];

   // In IDLE the request comes straight from the CPU pins; afterwards from the latched copy.
   always_comb begin
      if (state_q == IDLE) begin
         wr_e       = mem_write & ~mem_read;
         hi_e       = ~wr_e | mem_byte_enable[1];
         lo_e       = ~wr_e | mem_byte_enable[0];
         addr_e     = mem_address[15:1];
         wdata_hi_e = mem_wdata[15:8];
      end else begin
         wr_e       = wr_q;
         hi_e       = hi_q;
         lo_e       = 1'b0;
         addr_e     = addr_q;
         wdata_hi_e = wdata_hi_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               if (lo_e) begin
                  state_d = LO_ACT;
                  cnt_d   = CNT_LOAD;
               end else if (hi_e) begin
                  state_d = HI_ACT;
                  cnt_d   = CNT_LOAD;
               end else begin
                  // Empty write mask: one quiet cycle so completion lands one edge after accept.
                  state_d = HI_GAP;
               end
            end
         end
         LO_ACT: begin
            if (cnt_q == 4'd0) state_d = LO_GAP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         LO_GAP: begin
            if (hi_q) begin
               state_d = HI_ACT;
               cnt_d   = CNT_LOAD;
            end else begin
               state_d = RESP;
            end
         end
         HI_ACT: begin
            if (cnt_q == 4'd0) state_d = HI_GAP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         HI_GAP:  state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      act          = (state_d == LO_ACT) || (state_d == HI_ACT);
      resp_d       = (state_d == RESP);
      ce_n_d       = ~act;
      oe_n_d       = ~(act & ~wr_e);
      we_n_d       = ~(act & wr_e);
      sram_addr_d  = sram_addr_q;
      sram_wdata_d = sram_wdata_q;
      rdata_d      = rdata_q;
      if (state_d == LO_ACT && state_q != LO_ACT) begin
         sram_addr_d  = {addr_e, 1'b0};
         sram_wdata_d = mem_wdata[7:0];
      end else if (state_d == HI_ACT && state_q != HI_ACT) begin
         sram_addr_d  = {addr_e, 1'b1};
         sram_wdata_d = wdata_hi_e;
      end
      // Read byte is sampled on the edge that closes the active window.
      if (cnt_q == 4'd0 && !wr_q) begin
         if (state_q == LO_ACT)      rdata_d[7:0]  = sram_rdata;
         else if (state_q == HI_ACT) rdata_d[15:8] = sram_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q         <= 1'b0;
         hi_q         <= 1'b0;
         addr_q       <= '0;
         wdata_hi_q   <= '0;
         resp_q       <= 1'b0;
         rdata_q      <= '0;
         sram_addr_q  <= '0;
         sram_wdata_q <= '0;
         ce_n_q       <= 1'b1;
         oe_n_q       <= 1'b1;
         we_n_q       <= 1'b1;
      end else begin
         if (state_q == IDLE && req) begin
            wr_q       <= wr_e;
            hi_q       <= hi_e;
            addr_q     <= addr_e;
            wdata_hi_q <= wdata_hi_e;
         end
         resp_q       <= resp_d;
         rdata_q      <= rdata_d;
         sram_addr_q  <= sram_addr_d;
         sram_wdata_q <= sram_wdata_d;
         ce_n_q       <= ce_n_d;
         oe_n_q       <= oe_n_d;
         we_n_q       <= we_n_d;
      end
   end

   assign mem_resp   = resp_q;
   assign mem_rdata  = rdata_q;
   assign sram_addr  = sram_addr_q;
   assign sram_wdata = sram_wdata_q;
   assign sram_ce_n  = ce_n_q;
   assign sram_oe_n  = oe_n_q;
   assign sram_we_n  = we_n_q;

endmodule
